// File: rtl/mac_demo_pkg.sv
// Shared MAC demo constants: run-control FSM encodings and default datapath geometry.
package mac_demo_pkg;

    localparam int DEF_LEN      = 16;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_PIPE_LAT = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/mac_pipe_delay.sv
// DEPTH-cycle 1-bit delay line (rd_en -> mac_en); sync flush empties it, no backpressure.
module mac_pipe_delay #(
    parameter int DEPTH = 3
) (
    input  logic s_clk,
    input  logic reset_in,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge s_clk or posedge reset_in) begin
                if (reset_in)   sr <= '0;
                else if (flush) sr <= '0;
                else            sr <= din;
            end
        end else begin : g_chain
            always_ff @(posedge s_clk or posedge reset_in) begin
                if (reset_in)   sr <= '0;
                else if (flush) sr <= '0;
                else            sr <= {sr[DEPTH-2:0], din};
            end
        end
    endgenerate

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/mac_run_control.sv
// Responder side of start/aclr/done: clear, issue LEN reads, drain, one-cycle done.
// done arrives LEN+PIPE_LAT+2 cycles after start; start while busy is dropped.
module mac_run_control
    import mac_demo_pkg::*;
#(
    parameter int LEN      = DEF_LEN,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic              s_clk,
    input  logic              reset_in,
    input  logic              start,
    input  logic              aclr,
    output logic              done,
    output logic              busy,
    output logic              acc_clr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic              mac_en,
    output logic              result_valid
);

    // One extra bit so LEN = 2**ADDR_W terminates instead of wrapping.
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] ISSUE_LAST = CW'(LEN - 1);
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [DW-1:0] dcnt;

    assign cnt_nxt = cnt + 1'b1;

    always_ff @(posedge s_clk or posedge reset_in) begin
        if (reset_in) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            dcnt         <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            acc_clr      <= 1'b0;
            rd_en        <= 1'b0;
            addr         <= '0;
            result_valid <= 1'b0;
        end else if (aclr) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            dcnt         <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            acc_clr      <= 1'b0;
            rd_en        <= 1'b0;
            addr         <= '0;
            result_valid <= 1'b0;
        end else begin
            done    <= 1'b0;
            acc_clr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_CLEAR;
                        acc_clr      <= 1'b1;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        addr         <= '0;
                        cnt          <= '0;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_ISSUE;
                    rd_en <= 1'b1;
                end
                ST_ISSUE: begin
                    if (cnt == ISSUE_LAST) begin
                        state <= ST_DRAIN;
                        rd_en <= 1'b0;
                        dcnt  <= '0;
                    end else begin
                        cnt  <= cnt_nxt;
                        addr <= cnt_nxt[ADDR_W-1:0];
                    end
                end
                ST_DRAIN: begin
                    if (dcnt == DRAIN_LAST) begin
                        state        <= ST_DONE;
                        done         <= 1'b1;
                        result_valid <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    mac_pipe_delay #(.DEPTH(PIPE_LAT)) u_delay (
        .s_clk    (s_clk),
        .reset_in (reset_in),
        .flush    (aclr),
        .din      (rd_en),
        .dout     (mac_en)
    );

endmodule
